i2s_dac_arbiter: RTL and testbench

I2S_DAC_ARBITER -- requirements
Module: i2s_dac_arbiter

---
 rtl/i2s_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/i2s_dac_arbiter.sv | 111 +++++++++++
 tb/tb_i2s_dac_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and constants for the I2S DAC arbiter
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam int DWIDTH_DEF = 32;

  // Bit positions inside dac_tvalid / dac_tready
  localparam int CH_R = 0;
  localparam int CH_L = 1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick starting at ptr, wrapping mod N_REQ
module rr_arbiter
  import i2s_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner,
  output logic             any
);

  int best;
  int rel;

  // Winner is the requesting index with the smallest cyclic distance from ptr
  always_comb begin
    winner = '0;
    any    = 1'b0;
    best   = N_REQ;
    rel    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      rel = k - int'(ptr);
      if (rel < 0) rel = rel + N_REQ;
      if (req[k] && rel < best) begin
        best   = rel;
        winner = IW'(k);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_dac_arbiter.sv
// rtl/i2s_dac_arbiter.sv - round-robin arbiter feeding stereo pairs to an I2S DAC stream
module i2s_dac_arbiter
  import i2s_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DWIDTH-1:0] req_l_tdata,
  input  logic [N_REQ*DWIDTH-1:0] req_r_tdata,
  input  logic [N_REQ-1:0]        req_tvalid,
  output logic [N_REQ-1:0]        req_tready,
  input  logic [N_REQ-1:0]        req_mask,
  output logic [DWIDTH-1:0]       dac_r_tdata,
  output logic [DWIDTH-1:0]       dac_l_tdata,
  output logic [1:0]              dac_tvalid,
  input  logic [1:0]              dac_tready,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int IW = $clog2(N_REQ);

  state_t            state, state_n;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     win;
  logic [IW-1:0]     arb_win;
  logic              arb_any;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  onehot;
  logic [DWIDTH-1:0] sel_l, sel_r;
  logic [1:0]        dac_left;
  logic              cap;

  assign eligible = req_tvalid & req_mask;
  // Channels still owed after this cycle's handshakes
  assign dac_left = dac_tvalid & ~dac_tready;
  // req_tready is only ever high in the first SEND cycle; the pair transfers on that edge
  assign cap      = |req_tready;
  assign busy     = (state != IDLE);

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .req    (eligible),
    .ptr    (ptr),
    .winner (arb_win),
    .any    (arb_any)
  );

  // Select the held winner's samples and its one-hot ready
  always_comb begin
    sel_l  = '0;
    sel_r  = '0;
    onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win == IW'(k)) begin
        sel_l     = req_l_tdata[k*DWIDTH +: DWIDTH];
        sel_r     = req_r_tdata[k*DWIDTH +: DWIDTH];
        onehot[k] = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state: leave SEND once the pair is captured and both channels are accepted
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (arb_any) state_n = LOAD;
      LOAD:    state_n = SEND;
      SEND:    if (!cap && dac_left == 2'b00) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: winner hold, ready pulse, sample capture, per-channel valid, ptr advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win         <= '0;
      ptr         <= '0;
      grant_id    <= '0;
      req_tready  <= '0;
      dac_tvalid  <= 2'b00;
      dac_l_tdata <= '0;
      dac_r_tdata <= '0;
    end else begin
      if (state == IDLE && arb_any) win <= arb_win;
      req_tready <= '0;
      if (state == LOAD) begin
        req_tready <= onehot;
        grant_id   <= win;
      end
      if (cap) begin
        dac_l_tdata <= sel_l;
        dac_r_tdata <= sel_r;
        dac_tvalid  <= 2'b11;
      end else begin
        dac_tvalid[CH_R] <= dac_left[CH_R];
        dac_tvalid[CH_L] <= dac_left[CH_L];
      end
      if (state == SEND && state_n == IDLE)
        ptr <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_dac_arbiter.sv
// tb/tb_i2s_dac_arbiter.sv - self-checking bench for i2s_dac_arbiter
module tb_i2s_dac_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] req_l_tdata, req_r_tdata;
  logic [N-1:0]    req_tvalid, req_tready, req_mask;
  logic [DW-1:0]   dac_r_tdata, dac_l_tdata;
  logic [1:0]      dac_tvalid, dac_tready;
  logic [1:0]      grant_id;
  logic            busy;

  logic [DW-1:0]   l_d [N];
  logic [DW-1:0]   r_d [N];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] valid;
    logic [2:0] mask;
    int         exp_id;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  // Pack per-requester samples onto the flat buses
  always_comb begin
    req_l_tdata = '0;
    req_r_tdata = '0;
    for (int k = 0; k < N; k++) begin
      req_l_tdata[k*DW +: DW] = l_d[k];
      req_r_tdata[k*DW +: DW] = r_d[k];
    end
  end

  i2s_dac_arbiter #(.N_REQ(N), .DWIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_l_tdata (req_l_tdata),
    .req_r_tdata (req_r_tdata),
    .req_tvalid  (req_tvalid),
    .req_tready  (req_tready),
    .req_mask    (req_mask),
    .dac_r_tdata (dac_r_tdata),
    .dac_l_tdata (dac_l_tdata),
    .dac_tvalid  (dac_tvalid),
    .dac_tready  (dac_tready),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_rdy(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      step();
      if (req_tready != '0) ok = 1'b1;
    end
    chk({nm, "_wait_rdy"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      step();
      if (!busy) ok = 1'b1;
    end
    chk({nm, "_wait_idle"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_dac11(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      step();
      if (dac_tvalid == 2'b11) ok = 1'b1;
    end
    chk({nm, "_wait_dac11"}, 64'(ok), 64'd1);
  endtask

  // Reference round-robin: first masked index at or after p, cyclically
  function automatic int rr_pick(input int p, input logic [2:0] m);
    for (int i = 0; i < N; i++) begin
      if (m[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  initial begin
    logic [DW-1:0] exp_l, exp_r;
    logic [2:0]    mask_m;
    int            ptr_m, taking, grants, del_l, del_r, w, cnt;
    bit            flag;

    vecs[0] = '{3'b010, 3'b111,  1};
    vecs[1] = '{3'b111, 3'b111,  2};
    vecs[2] = '{3'b111, 3'b110,  1};
    vecs[3] = '{3'b011, 3'b111,  0};
    vecs[4] = '{3'b101, 3'b111,  2};
    vecs[5] = '{3'b100, 3'b111,  2};
    vecs[6] = '{3'b111, 3'b100,  2};
    vecs[7] = '{3'b001, 3'b001,  0};
    vecs[8] = '{3'b111, 3'b000, -1};

    rst = 1'b1; req_tvalid = '0; req_mask = '0; dac_tready = 2'b00;
    for (int k = 0; k < N; k++) begin l_d[k] = '0; r_d[k] = '0; end
    step(); step();
    chk("rst_tready", 64'(req_tready), 64'd0);
    chk("rst_dac_tvalid", 64'(dac_tvalid), 64'd0);
    chk("rst_dac_l", 64'(dac_l_tdata), 64'd0);
    chk("rst_dac_r", 64'(dac_r_tdata), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // Single requester 1, latency to ready and to both DAC valids
    req_mask = 3'b111; l_d[1] = 32'h11111111; r_d[1] = 32'h22222222;
    dac_tready = 2'b11; req_tvalid = 3'b010;
    step();
    chk("lat_rdy_c1", 64'(req_tready), 64'd0);
    step();
    chk("lat_rdy_c2", 64'(req_tready), 64'b010);
    req_tvalid = '0;
    step();
    chk("lat_dac_c3", 64'(dac_tvalid), 64'b11);
    chk("one_l", 64'(dac_l_tdata), 64'h11111111);
    chk("one_r", 64'(dac_r_tdata), 64'h22222222);
    chk("one_rdy_pulse", 64'(req_tready), 64'd0);
    chk("one_grant", 64'(grant_id), 64'd1);
    step();
    chk("one_done_tvalid", 64'(dac_tvalid), 64'd0);
    chk("one_done_busy", 64'(busy), 64'd0);

    // Channels accepted far apart; no new grant until both done
    l_d[0] = $urandom; r_d[0] = $urandom; dac_tready = 2'b00; req_tvalid = 3'b001;
    wait_dac11("split");
    chk("split_grant", 64'(grant_id), 64'd0);
    req_tvalid = 3'b100;
    flag = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (req_tready != '0 || dac_tvalid != 2'b11 || !busy) flag = 1'b1;
    end
    chk("split_hold_a", 64'(flag), 64'd0);
    dac_tready = 2'b01;
    step();
    chk("split_r_done", 64'(dac_tvalid), 64'b10);
    chk("split_busy_a", 64'(busy), 64'd1);
    dac_tready = 2'b00;
    flag = 1'b0;
    for (int i = 0; i < 39; i++) begin
      step();
      if (req_tready != '0 || dac_tvalid != 2'b10 || !busy) flag = 1'b1;
    end
    chk("split_hold_b", 64'(flag), 64'd0);
    dac_tready = 2'b10;
    step();
    chk("split_l_done", 64'(dac_tvalid), 64'b00);
    chk("split_busy_end", 64'(busy), 64'd0);
    wait_rdy("split_next");
    chk("split_next_id", 64'(req_tready), 64'b100);
    req_tvalid = '0; dac_tready = 2'b11;
    wait_idle("split_next");

    // Grantee withdraws valid and mask mid-frame; pair still delivered
    l_d[0] = $urandom; r_d[0] = $urandom; req_tvalid = 3'b111; dac_tready = 2'b00;
    wait_rdy("drop");
    chk("drop_id", 64'(req_tready), 64'b001);
    exp_l = l_d[0]; exp_r = r_d[0];
    req_tvalid = '0; req_mask = '0;
    for (int i = 0; i < 4; i++) step();
    chk("drop_hold", 64'(dac_tvalid), 64'b11);
    dac_tready = 2'b01;
    step();
    chk("drop_r_done", 64'(dac_tvalid), 64'b10);
    chk("drop_l_data", 64'(dac_l_tdata), 64'(exp_l));
    chk("drop_r_data", 64'(dac_r_tdata), 64'(exp_r));
    dac_tready = 2'b10;
    step();
    chk("drop_done", 64'(dac_tvalid), 64'b00);

    // Reset mid-SEND clears everything at once; arbitration restarts from 0
    req_tvalid = 3'b111; req_mask = 3'b111; dac_tready = 2'b00;
    wait_dac11("rstmid");
    chk("rstmid_grant", 64'(grant_id), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("rstmid_tvalid", 64'(dac_tvalid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_grant0", 64'(grant_id), 64'd0);
    chk("rstmid_data", 64'({dac_l_tdata, dac_r_tdata}), 64'd0);
    step();
    rst = 1'b0;
    wait_rdy("rstmid_after");
    chk("rstmid_after_id", 64'(req_tready), 64'b001);
    req_tvalid = '0; dac_tready = 2'b11;
    wait_idle("rstmid_after");

    // Table vectors from a fresh reset, ptr carried across entries
    rst = 1'b1; step(); rst = 1'b0;
    for (int v = 0; v < 9; v++) begin
      req_tvalid = vecs[v].valid; req_mask = vecs[v].mask; dac_tready = 2'b11;
      if (vecs[v].exp_id < 0) begin
        flag = 1'b0;
        for (int i = 0; i < 8; i++) begin
          step();
          if (req_tready != '0 || dac_tvalid != 2'b00 || busy) flag = 1'b1;
        end
        chk($sformatf("vec%0d_none", v), 64'(flag), 64'd0);
      end else begin
        wait_rdy($sformatf("vec%0d", v));
        chk($sformatf("vec%0d_rdy", v), 64'(req_tready), 64'd1 << vecs[v].exp_id);
        req_tvalid = '0;
        wait_idle($sformatf("vec%0d", v));
        chk($sformatf("vec%0d_gid", v), 64'(grant_id), 64'(vecs[v].exp_id));
      end
    end
    req_tvalid = '0;

    // Randomized: all requesters saturating, random mask and DAC back-pressure
    for (int seg = 0; seg < 6; seg++) begin
      mask_m = (seg == 0) ? 3'b101 : 3'($urandom_range(1, 7));
      req_mask = mask_m;
      rst = 1'b1; step(); rst = 1'b0;
      ptr_m = 0; taking = -1; grants = 0; del_l = 0; del_r = 0; cnt = 0;
      for (int k = 0; k < N; k++) begin l_d[k] = $urandom; r_d[k] = $urandom; end
      req_tvalid = '1; dac_tready = 2'b00;
      exp_l = '0; exp_r = '0;
      for (int cyc = 0; cyc < 200; cyc++) begin
        step();
        if (taking >= 0) begin
          l_d[taking] = $urandom; r_d[taking] = $urandom; taking = -1;
        end
        if (req_tready != '0) begin
          w = rr_pick(ptr_m, mask_m);
          chk("rnd_grant", 64'(req_tready), 64'd1 << w);
          ptr_m = (w + 1) % N;
          exp_l = l_d[w]; exp_r = r_d[w]; taking = w; grants++;
        end
        if (cyc >= 185) begin
          req_tvalid = '0; dac_tready = 2'b11;
        end else begin
          dac_tready = 2'($urandom);
        end
        if (dac_tvalid[0]) chk("rnd_r_data", 64'(dac_r_tdata), 64'(exp_r));
        if (dac_tvalid[1]) chk("rnd_l_data", 64'(dac_l_tdata), 64'(exp_l));
        if (dac_tvalid[0] && dac_tready[0]) del_r++;
        if (dac_tvalid[1] && dac_tready[1]) del_l++;
      end
      chk("rnd_some_grants", 64'(grants > 4), 64'd1);
      chk("rnd_del_l", 64'(del_l), 64'(grants));
      chk("rnd_del_r", 64'(del_r), 64'(grants));
      chk("rnd_idle", 64'(busy), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
